// File: rtl/key_seg_pkg.sv
// rtl/key_seg_pkg.sv - shared types and constants for the key/segment path
//
// Purpose: FSM state encoding for keypad_scan, special key codes and the
//          counter-width helper used to size the scan and debounce counters.
// Ports:   none (package).

package key_seg_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    WAIT_REL = 2'd2
  } kp_state_t;

  localparam logic [3:0] KEY_CLR   = 4'd12;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Bits needed to hold the values 0..n; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/digit_shift_buf.sv
// rtl/digit_shift_buf.sv - six-digit shift buffer feeding the display scanner
//
// Purpose: shifts accepted digits in from the newest end (dis6) and drops the
//          oldest (dis1); clr zeroes all six digits.
// Ports:   clk, rst_n (sync, active-low), load (shift din in), clr (zero all),
//          din[3:0] (digit), dis1..dis6[3:0] (dis1 oldest, dis6 newest).

module digit_shift_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       clr,
  input  logic [3:0] din,
  output logic [3:0] dis1,
  output logic [3:0] dis2,
  output logic [3:0] dis3,
  output logic [3:0] dis4,
  output logic [3:0] dis5,
  output logic [3:0] dis6
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      dis1 <= 4'd0;
      dis2 <= 4'd0;
      dis3 <= 4'd0;
      dis4 <= 4'd0;
      dis5 <= 4'd0;
      dis6 <= 4'd0;
    end else if (load) begin
      dis1 <= dis2;
      dis2 <= dis3;
      dis3 <= dis4;
      dis4 <= dis5;
      dis5 <= dis6;
      dis6 <= din;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with debounce and digit buffer
//
// Purpose: rotates one active-low row at a time, detects a pressed column,
//          debounces it, emits one key_valid pulse per press and feeds digits
//          into a six-digit buffer for the display scanner.
// Ports:   clk, rst_n (sync, active-low), col[3:0] (async, active-low),
//          row[3:0] (one bit low), key_code[3:0] (row*4+col of last key),
//          key_valid (1-cycle pulse), dis1..dis6[3:0] (digit buffer).

module keypad_scan #(
  parameter int SCAN_CYCLES = 50_000,
  parameter int DEB_CYCLES  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] dis1,
  output logic [3:0] dis2,
  output logic [3:0] dis3,
  output logic [3:0] dis4,
  output logic [3:0] dis5,
  output logic [3:0] dis6
);

  import key_seg_pkg::*;

  localparam int SW = cnt_width(SCAN_CYCLES);
  localparam int DW = cnt_width(DEB_CYCLES);
  localparam logic [SW-1:0] DWELL_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

  // Lowest-index low column wins when several are pressed together.
  function automatic logic [1:0] low_col(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  logic [3:0]    col_meta, col_s, col_lat, col_lat_nxt;
  kp_state_t     state, state_nxt;
  logic [1:0]    row_idx, row_idx_nxt;
  logic [SW-1:0] dwell_cnt, dwell_nxt;
  logic [DW-1:0] deb_cnt, deb_nxt;
  logic          fire;
  logic [3:0]    code;
  logic          buf_load, buf_clr;

  assign row      = ~(4'b0001 << row_idx);
  assign code     = {row_idx, low_col(col_lat)};
  assign buf_load = fire && (code <= DIGIT_MAX);
  assign buf_clr  = fire && (code == KEY_CLR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_meta  <= 4'hF;
      col_s     <= 4'hF;
      state     <= SCAN;
      row_idx   <= 2'd0;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      col_lat   <= 4'hF;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      col_meta  <= col;
      col_s     <= col_meta;
      state     <= state_nxt;
      row_idx   <= row_idx_nxt;
      dwell_cnt <= dwell_nxt;
      deb_cnt   <= deb_nxt;
      col_lat   <= col_lat_nxt;
      key_valid <= fire;
      if (fire) key_code <= code;
    end
  end

  always_comb begin
    state_nxt   = state;
    row_idx_nxt = row_idx;
    dwell_nxt   = dwell_cnt;
    deb_nxt     = deb_cnt;
    col_lat_nxt = col_lat;
    fire        = 1'b0;
    unique case (state)
      SCAN: begin
        // Sample only on the last dwell cycle so the columns have settled
        // through the synchronizer after the row change.
        if (dwell_cnt >= DWELL_LAST) begin
          dwell_nxt = '0;
          if (col_s != 4'hF) begin
            col_lat_nxt = col_s;
            deb_nxt     = '0;
            state_nxt   = DEBOUNCE;
          end else begin
            row_idx_nxt = row_idx + 2'd1;
          end
        end else begin
          dwell_nxt = dwell_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s != col_lat) begin
          // Bounce: restart the dwell on the same row.
          state_nxt = SCAN;
          dwell_nxt = '0;
          deb_nxt   = '0;
        end else if (deb_cnt >= DEB_LAST) begin
          // The pulse register lands on the DEB_CYCLES-th edge after entry.
          fire      = 1'b1;
          deb_nxt   = '0;
          state_nxt = WAIT_REL;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      WAIT_REL: begin
        if (col_s != 4'hF) begin
          deb_nxt = '0;
        end else if (deb_cnt >= DEB_LAST) begin
          deb_nxt     = '0;
          dwell_nxt   = '0;
          row_idx_nxt = row_idx + 2'd1;
          state_nxt   = SCAN;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  digit_shift_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load),
    .clr   (buf_clr),
    .din   (code),
    .dis1  (dis1),
    .dis2  (dis2),
    .dis3  (dis3),
    .dis4  (dis4),
    .dis5  (dis5),
    .dis6  (dis6)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan

module tb_keypad_scan;
  import key_seg_pkg::*;

  localparam int SCAN = 4;
  localparam int DEB  = 16;
  localparam int MAX_LAT = 4 * SCAN + 2 + DEB;

  typedef struct {
    int         k;
    logic [3:0] row;
    logic       kv;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col, row, key_code;
  logic       key_valid;
  logic [3:0] dis1, dis2, dis3, dis4, dis5, dis6;

  // Keypad model: pressed columns pull low only while the key's row is driven.
  logic       key_on = 1'b0;
  logic       bounce_open = 1'b0;
  logic [1:0] key_row = 2'd0;
  logic [3:0] key_cols = 4'd0;
  assign col = (key_on && !bounce_open && !row[key_row]) ? ~key_cols : 4'hF;

  keypad_scan #(.SCAN_CYCLES(SCAN), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .col(col), .row(row),
    .key_code(key_code), .key_valid(key_valid),
    .dis1(dis1), .dis2(dis2), .dis3(dis3),
    .dis4(dis4), .dis5(dis5), .dis6(dis6)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  int deb_entry_cyc = 0;
  int pulse_gap = -1;
  logic in_deb = 1'b0;

  logic [3:0] mbuf [6];

  always @(posedge clk) begin
    #2;
    cyc++;
    if (dut.state == DEBOUNCE && !in_deb) deb_entry_cyc = cyc;
    in_deb = (dut.state == DEBOUNCE);
    if (key_valid) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      pulse_gap = cyc - deb_entry_cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] dut_dis();
    return {dis1, dis2, dis3, dis4, dis5, dis6};
  endfunction

  function automatic logic [23:0] model_dis();
    return {mbuf[0], mbuf[1], mbuf[2], mbuf[3], mbuf[4], mbuf[5]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 6; i++) mbuf[i] = 4'd0;
  endtask

  task automatic model_accept(input logic [3:0] c);
    if (c <= 4'd9) begin
      for (int i = 0; i < 5; i++) mbuf[i] = mbuf[i + 1];
      mbuf[5] = c;
    end else if (c == 4'd12) begin
      model_clear();
    end
  endtask

  task automatic wait_pulse(input int start, input int t0);
    while (pulse_cnt == start && cyc - t0 < MAX_LAT + 8) @(negedge clk);
  endtask

  // Press a key (possibly several columns), optionally bouncing first, then
  // check one pulse, its code, timing, the buffer, and no repeat while held.
  task automatic do_press(input logic [1:0] r, input logic [3:0] cm,
                          input int bounce_cyc, input int hold);
    int start, t0, ci;
    logic [3:0] exp_code;
    ci = 0;
    while (ci < 3 && !cm[ci]) ci++;
    exp_code = 4'(int'(r) * 4 + ci);
    start = pulse_cnt;
    @(negedge clk);
    key_row = r;
    key_cols = cm;
    bounce_open = 1'b0;
    key_on = 1'b1;
    for (int i = 0; i < bounce_cyc; i++) begin
      @(negedge clk);
      if (i % 5 == 4) bounce_open = ~bounce_open;
    end
    bounce_open = 1'b0;
    if (bounce_cyc > 0) chk("no_pulse_while_bouncing", pulse_cnt - start, 0);
    t0 = cyc;
    wait_pulse(start, t0);
    chk("pulse_seen", pulse_cnt - start, 1);
    chk("latency_in_bound", (last_pulse_cyc - t0 <= MAX_LAT) && (last_pulse_cyc - t0 >= DEB), 1);
    chk("debounce_to_pulse", pulse_gap, DEB);
    chk("key_code", key_code, exp_code);
    model_accept(exp_code);
    chk("dis_buffer", dut_dis(), model_dis());
    repeat (hold) @(negedge clk);
    key_on = 1'b0;
    repeat (3 * DEB) @(negedge clk);
    chk("single_pulse", pulse_cnt - start, 1);
  endtask

  logic [3:0] seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
  vec_t tbl [20];

  initial begin
    int start, t0;
    logic [23:0] saved;

    for (int k = 0; k < 20; k++) begin
      tbl[k].k   = k;
      tbl[k].row = seq[k / 4];
      tbl[k].kv  = 1'b0;
    end
    model_clear();

    // Reset, no key
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_row", row, 4'b1110);
    chk("reset_key_valid", key_valid, 0);
    chk("reset_key_code", key_code, 0);
    chk("reset_dis", dut_dis(), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("row_rotation_k%0d", tbl[i].k), row, tbl[i].row);
      chk("idle_key_valid", key_valid, tbl[i].kv);
    end
    chk("idle_no_pulses", pulse_cnt, 0);
    chk("idle_dis", dut_dis(), 0);

    // Digit entry
    do_press(2'd1, 4'b0010, 0, 40);
    chk("digit5_dis", dut_dis(), 24'h000005);
    do_press(2'd0, 4'b0100, 0, 10);
    chk("digit2_dis", dut_dis(), 24'h000052);

    // Bounce
    do_press(2'd1, 4'b0100, 30, 10);

    // Wrap and clear
    for (int d = 1; d <= 7; d++)
      do_press(2'(d / 4), 4'(1 << (d % 4)), 0, 5);
    chk("wrap_dis", dut_dis(), 24'h234567);
    do_press(2'd3, 4'b0001, 0, 5);
    chk("clear_code", key_code, 12);
    chk("clear_dis", dut_dis(), 0);

    // Non-digit and multi-column
    do_press(2'd0, 4'b0010, 0, 5);
    do_press(2'd2, 4'b0001, 0, 5);
    saved = dut_dis();
    do_press(2'd2, 4'b0100, 0, 5);
    chk("nondigit_code", key_code, 10);
    chk("nondigit_dis_unchanged", dut_dis(), saved);
    do_press(2'd0, 4'b1010, 0, 5);
    chk("multicol_code", key_code, 1);

    // Reset mid-debounce
    start = pulse_cnt;
    @(negedge clk);
    key_row = 2'd1;
    key_cols = 4'b1000;
    key_on = 1'b1;
    t0 = cyc;
    while (dut.state != DEBOUNCE && cyc - t0 < MAX_LAT) @(negedge clk);
    chk("debounce_reached", dut.state == DEBOUNCE, 1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_row", row, 4'b1110);
    chk("midrst_dis", dut_dis(), 0);
    chk("midrst_key_valid", key_valid, 0);
    chk("midrst_no_pulse", pulse_cnt - start, 0);
    model_clear();
    rst_n = 1'b1;
    t0 = cyc;
    wait_pulse(start, t0);
    chk("redetect_pulse", pulse_cnt - start, 1);
    chk("redetect_code", key_code, 7);
    model_accept(4'd7);
    chk("redetect_dis", dut_dis(), model_dis());
    key_on = 1'b0;
    repeat (3 * DEB) @(negedge clk);
    chk("redetect_single", pulse_cnt - start, 1);

    // Randomized presses against the reference model
    for (int i = 0; i < 12; i++) begin
      do_press(2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)),
               ($urandom_range(0, 2) == 0) ? 30 : 0, $urandom_range(0, 20));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
